// File: rtl/serial_ctrl_pkg.sv
// Shared types and defaults for the character-serial send/receive blocks.
package serial_ctrl_pkg;

   // Character frame: start, 8 data, stop.
   localparam int FRAME_BITS_DEF = 10;
   // Width of the transmitter's bit-in-character count.
   localparam int BIC_W          = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      GAP  = 2'd3
   } sched_state_e;

   // One-hot winner of a 2-way round-robin: a lone requester always wins,
   // a tie goes to whoever was not granted last.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_grant);
      logic [1:0] g;
      g = req;
      if (req == 2'b11) g = last_grant ? 2'b01 : 2'b10;
      return g;
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Requester / transmitter handshake bundle around tx_frame_scheduler.
interface tx_frame_scheduler_if
   import serial_ctrl_pkg::*;
();
   logic [1:0]       req;
   logic [7:0]       data0;
   logic [7:0]       data1;
   logic [1:0]       ack;
   logic             tx_load;
   logic             tx_transmit;
   logic [7:0]       tx_data;
   logic [BIC_W-1:0] tx_bic;
   logic             busy;
   logic             frame_done;
   logic             timeout;

   // Scheduler side.
   modport slave (
      input  req, data0, data1, tx_bic,
      output ack, tx_load, tx_transmit, tx_data, busy, frame_done, timeout
   );

   // Requesters plus transmitter side.
   modport master (
      output req, data0, data1, tx_bic,
      input  ack, tx_load, tx_transmit, tx_data, busy, frame_done, timeout
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; remembers the last accepted winner.
module rr_arbiter2
   import serial_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);
   logic last_grant_q, last_grant_d;

   // Winner from current requests; history only moves on an accepted grant.
   always_comb begin
      gnt          = rr_pick(req, last_grant_q);
      last_grant_d = last_grant_q;
      if (accept && (gnt != 2'b00)) last_grant_d = gnt[1];
   end

   // last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant_q <= 1'b1;
      else     last_grant_q <= last_grant_d;
   end
endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares the character-serial transmitter between two byte sources:
// arbitrates, latches the byte, runs load/transmit and watches tx_bic
// for the end of the frame, then enforces an inter-frame gap.
module tx_frame_scheduler
   import serial_ctrl_pkg::*;
#(
   parameter int FRAME_BITS     = FRAME_BITS_DEF,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input logic                  clk,
   input logic                  reset,
   tx_frame_scheduler_if.slave  bus
);
   localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int               GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(FRAME_BITS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

   sched_state_e     state_q, state_d;
   logic [1:0]       ack_q, ack_d;
   logic             tx_load_q, tx_load_d;
   logic             tx_transmit_q, tx_transmit_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             timeout_q, timeout_d;
   logic [BIC_W-1:0] bic_prev_q, bic_prev_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

   logic [1:0]       gnt;
   logic             accept;
   logic             done;

   // Grants are only taken in IDLE, so a requester that keeps req high for
   // a cycle after its ack cannot be accepted twice.
   assign accept = (state_q == IDLE) && (bus.req != 2'b00);

   // Frame ends on the counter wrap only; a drop to 0 from any other count
   // is a glitch, not a completion.
   assign done = (bic_prev_q == BIC_LAST) && (bus.tx_bic == '0);

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (reset),
      .req    (bus.req),
      .accept (accept),
      .gnt    (gnt)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d       = state_q;
      ack_d         = 2'b00;
      tx_load_d     = 1'b0;
      tx_transmit_d = 1'b0;
      tx_data_d     = tx_data_q;
      frame_done_d  = 1'b0;
      timeout_d     = 1'b0;
      bic_prev_d    = bic_prev_q;
      tmo_cnt_d     = tmo_cnt_q;
      gap_cnt_d     = gap_cnt_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = LOAD;
               ack_d     = gnt;
               tx_load_d = 1'b1;
               tx_data_d = gnt[1] ? bus.data1 : bus.data0;
            end
         end

         LOAD: begin
            state_d       = SEND;
            tx_transmit_d = 1'b1;
            tmo_cnt_d     = '0;
            bic_prev_d    = '0;
         end

         SEND: begin
            bic_prev_d = bus.tx_bic;
            if (done) begin
               frame_done_d = 1'b1;
               gap_cnt_d    = '0;
               state_d      = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else if (tmo_cnt_q == TMO_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tx_transmit_d = 1'b1;
               // Saturate rather than wrap.
               if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = IDLE;
            else                               gap_cnt_d = gap_cnt_q + 1'b1;
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   // State, counters, byte latch and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         ack_q         <= 2'b00;
         tx_load_q     <= 1'b0;
         tx_transmit_q <= 1'b0;
         tx_data_q     <= 8'h00;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_q     <= 1'b0;
         bic_prev_q    <= '0;
         tmo_cnt_q     <= '0;
         gap_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         ack_q         <= ack_d;
         tx_load_q     <= tx_load_d;
         tx_transmit_q <= tx_transmit_d;
         tx_data_q     <= tx_data_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         timeout_q     <= timeout_d;
         bic_prev_q    <= bic_prev_d;
         tmo_cnt_q     <= tmo_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
      end
   end

   assign bus.ack         = ack_q;
   assign bus.tx_load     = tx_load_q;
   assign bus.tx_transmit = tx_transmit_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.busy        = busy_q;
   assign bus.frame_done  = frame_done_q;
   assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler.
module tb_tx_frame_scheduler;
   localparam int FB  = 10;
   localparam int G   = 2;
   localparam int TMO = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   tx_frame_scheduler_if bus ();

   tx_frame_scheduler #(
      .FRAME_BITS     (FB),
      .GAP_CYCLES     (G),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Transmitter stand-in: counts 0..FB-1 while tx_transmit is held,
   // starting from 0 on the first transmit cycle; manual value otherwise.
   logic       auto_bic = 1'b0;
   logic [3:0] man_bic  = 4'd0;
   logic [3:0] bic_auto = 4'd0;
   logic       tx_prev  = 1'b0;

   assign bus.tx_bic = auto_bic ? bic_auto : man_bic;

   always @(negedge clk) begin
      if (!bus.tx_transmit || !tx_prev) bic_auto <= 4'd0;
      else                              bic_auto <= (bic_auto == 4'(FB - 1)) ? 4'd0 : bic_auto + 4'd1;
      tx_prev <= bus.tx_transmit;
   end

   typedef struct {
      logic [1:0] req;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [3:0] bic;
      logic [1:0] ack;
      logic       ld;
      logic       tx;
      logic       bsy;
      logic       dn;
      logic [7:0] dat;
   } vec_t;

   vec_t       tbl [16];
   logic [3:0] fd_seq [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string pfx);
      chk({pfx, "_ack"},   bus.ack,         2'b00);
      chk({pfx, "_load"},  bus.tx_load,     1'b0);
      chk({pfx, "_tx"},    bus.tx_transmit, 1'b0);
      chk({pfx, "_data"},  bus.tx_data,     8'h00);
      chk({pfx, "_busy"},  bus.busy,        1'b0);
      chk({pfx, "_done"},  bus.frame_done,  1'b0);
      chk({pfx, "_tmo"},   bus.timeout,     1'b0);
   endtask

   task automatic do_reset();
      bus.req   = 2'b00;
      bus.data0 = 8'h00;
      bus.data1 = 8'h00;
      auto_bic  = 1'b0;
      man_bic   = 4'd0;
      reset     = 1'b1;
      repeat (2) step();
      reset     = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] rq, ea, prev_ack;
      logic [7:0] dd0, dd1, eb;
      logic       lg, seen, sawdone;
      int         free_e, g_e, dn_e, w, ng, last_e, cyc;

      // ---- reset state ----
      bus.req = 2'b00; bus.data0 = 8'h00; bus.data1 = 8'h00;
      #1 reset = 1'b1;
      #1 chk_quiet("reset");
      repeat (2) step();
      reset = 1'b0;

      // ---- table: single request, full frame, gap enforcement ----
      tbl[0] = '{2'b01, 8'hA5, 8'h00, 4'd0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
      tbl[1] = '{2'b00, 8'hA5, 8'h00, 4'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
      for (int i = 0; i < 10; i++)
         tbl[2 + i] = '{2'b00, 8'hA5, 8'h00, 4'(i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
      tbl[12] = '{2'b00, 8'hA5, 8'h00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5};
      tbl[13] = '{2'b00, 8'hA5, 8'h00, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
      tbl[14] = '{2'b10, 8'hA5, 8'h3C, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
      tbl[15] = '{2'b10, 8'hA5, 8'h3C, 4'd0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
      for (int i = 0; i < 16; i++) begin
         bus.req = tbl[i].req; bus.data0 = tbl[i].d0; bus.data1 = tbl[i].d1; man_bic = tbl[i].bic;
         step();
         chk($sformatf("tbl%0d_ack", i),  bus.ack,         tbl[i].ack);
         chk($sformatf("tbl%0d_load", i), bus.tx_load,     tbl[i].ld);
         chk($sformatf("tbl%0d_tx", i),   bus.tx_transmit, tbl[i].tx);
         chk($sformatf("tbl%0d_busy", i), bus.busy,        tbl[i].bsy);
         chk($sformatf("tbl%0d_done", i), bus.frame_done,  tbl[i].dn);
         chk($sformatf("tbl%0d_data", i), bus.tx_data,     tbl[i].dat);
         chk($sformatf("tbl%0d_tmo", i),  bus.timeout,     1'b0);
      end

      // ---- contention: held 11 -> 11,22,11,22 with gap spacing ----
      do_reset();
      auto_bic = 1'b1;
      bus.req = 2'b11; bus.data0 = 8'h11; bus.data1 = 8'h22;
      ng = 0; last_e = 0; prev_ack = 2'b00;
      for (int k = 0; k < 80 && ng < 4; k++) begin
         step();
         if (prev_ack != 2'b00) chk("cont_ack_pulse", bus.ack, 2'b00);
         else if (bus.ack != 2'b00) begin
            chk("cont_order", bus.ack, (ng % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_data", bus.tx_data, (ng % 2 == 0) ? 8'h11 : 8'h22);
            if (ng > 0) chk("cont_spacing", k - last_e, FB + 3 + G);
            last_e = k;
            ng++;
         end
         prev_ack = bus.ack;
      end
      chk("cont_grants", ng, 4);

      // ---- timeout with tx_bic stuck at 3 ----
      do_reset();
      man_bic = 4'd3;
      bus.req = 2'b01; bus.data0 = 8'h77;
      step();
      chk("to_ack", bus.ack, 2'b01);
      bus.req = 2'b00;
      seen = 1'b0; sawdone = 1'b0; cyc = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         step();
         if (bus.frame_done) sawdone = 1'b1;
         if (bus.timeout) begin seen = 1'b1; cyc = k; end
      end
      chk("to_seen", seen, 1'b1);
      chk("to_cycles", cyc, TMO + 1);
      chk("to_no_done", sawdone, 1'b0);
      chk("to_busy", bus.busy, 1'b0);
      chk("to_tx", bus.tx_transmit, 1'b0);
      step();
      chk("to_pulse", bus.timeout, 1'b0);
      bus.req = 2'b10; bus.data1 = 8'h88;
      step();
      chk("to_regrant", bus.ack, 2'b10);
      chk("to_regrant_data", bus.tx_data, 8'h88);

      // ---- false done: 0,1,2,0 glitch then a real 9->0 wrap ----
      fd_seq = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
      do_reset();
      bus.req = 2'b01; bus.data0 = 8'h5A;
      step();
      chk("fd_ack", bus.ack, 2'b01);
      bus.req = 2'b00;
      step();
      chk("fd_load_tx", bus.tx_transmit, 1'b1);
      for (int i = 0; i < 14; i++) begin
         man_bic = fd_seq[i];
         step();
         chk($sformatf("fd_done%0d", i), bus.frame_done, (i == 13));
      end
      chk("fd_tx_off", bus.tx_transmit, 1'b0);
      chk("fd_data", bus.tx_data, 8'h5A);

      // ---- reset in the middle of SEND ----
      do_reset();
      auto_bic = 1'b1;
      bus.req = 2'b01; bus.data0 = 8'hC3;
      step();
      bus.req = 2'b00;
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         step();
         if (bic_auto == 4'd5 && bus.tx_transmit) seen = 1'b1;
      end
      chk("rm_reach_bic5", seen, 1'b1);
      #2 reset = 1'b1;
      #1 chk_quiet("rm_async");
      step();
      reset = 1'b0;
      bus.req = 2'b11; bus.data0 = 8'h11; bus.data1 = 8'h22;
      step();
      chk("rm_first_grant", bus.ack, 2'b01);
      chk("rm_first_data", bus.tx_data, 8'h11);

      // ---- random traffic against a timeline model ----
      do_reset();
      auto_bic = 1'b1;
      rq = 2'b00; dd0 = 8'h00; dd1 = 8'h00; eb = 8'h00;
      lg = 1'b1; free_e = 0; g_e = -100; w = 0;
      for (int k = 0; k < 700; k++) begin
         bus.req = rq; bus.data0 = dd0; bus.data1 = dd1;
         step();
         ea = 2'b00;
         if (k >= free_e && rq != 2'b00) begin
            w      = (rq == 2'b11) ? (lg ? 0 : 1) : (rq[1] ? 1 : 0);
            g_e    = k;
            eb     = (w == 1) ? dd1 : dd0;
            lg     = (w == 1);
            free_e = k + FB + 3 + G;
            ea     = (w == 1) ? 2'b10 : 2'b01;
         end
         dn_e = g_e + 2 + FB;
         chk("rnd_ack",  bus.ack,         ea);
         chk("rnd_load", bus.tx_load,     (k == g_e));
         chk("rnd_tx",   bus.tx_transmit, (k >= g_e + 1) && (k < dn_e));
         chk("rnd_busy", bus.busy,        (k >= g_e) && (k < dn_e + G));
         chk("rnd_done", bus.frame_done,  (k == dn_e));
         chk("rnd_tmo",  bus.timeout,     1'b0);
         chk("rnd_data", bus.tx_data,     eb);
         for (int i = 0; i < 2; i++) begin
            if (ea[i]) begin
               rq[i] = ($urandom_range(3) == 0);
               if (i == 0) dd0 = 8'($urandom); else dd1 = 8'($urandom);
            end else if (!rq[i] && $urandom_range(2) == 0) begin
               rq[i] = 1'b1;
               if (i == 0) dd0 = 8'($urandom); else dd1 = 8'($urandom);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
